// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter and its source queues.
package cdb_arbiter_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int WORD_W    = 32;

    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TP;
    typedef logic [WORD_W-1:0]    WORD_TP;

    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;
    localparam WORD_TP    ZERO_WORD    = '0;
    localparam logic      TRUE         = 1'b1;
    localparam logic      FALSE        = 1'b0;

    typedef struct packed {
        ROB_IDX_TP src;
        WORD_TP    val;
    } cdb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

endpackage

// File: rtl/cdb_src_queue.sv
// Per-source completion FIFO with registered almost-full flag and rollback flush.
module cdb_src_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int QUEUE_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 push,
    input  logic [ROB_IDX_W-1:0] push_src,
    input  logic [WORD_W-1:0]    push_val,
    input  logic                 pop,
    output logic [ROB_IDX_W-1:0] head_src,
    output logic [WORD_W-1:0]    head_val,
    output logic                 empty,
    output logic                 full
);

    localparam logic [QUEUE_AW:0] DEPTH_C  = (QUEUE_AW+1)'(QUEUE_DEPTH);
    localparam logic [QUEUE_AW:0] ALMOST_C = (QUEUE_AW+1)'(QUEUE_DEPTH - 1);

    cdb_entry_t             mem_q [QUEUE_DEPTH];
    logic [QUEUE_AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QUEUE_AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [QUEUE_AW:0]      count_q, count_d;
    logic                   full_q;
    logic                   do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (count_q != DEPTH_C);
        rd_ptr_d = rd_ptr_q + QUEUE_AW'(do_pop);
        wr_ptr_d = wr_ptr_q + QUEUE_AW'(do_push);
        count_d  = count_q + (QUEUE_AW+1)'(do_push) - (QUEUE_AW+1)'(do_pop);
    end

    // Full leaves one spare slot for the result already in flight from the producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= FALSE;
        end else if (rdy) begin
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                full_q   <= FALSE;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                full_q   <= (count_d >= ALMOST_C);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush && do_push) begin
            mem_q[wr_ptr_q] <= '{src: push_src, val: push_val};
        end
    end

    assign head_src = mem_q[rd_ptr_q].src;
    assign head_val = mem_q[rd_ptr_q].val;
    assign empty    = (count_q == '0);
    assign full     = full_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter between ALU and load completions with per-source bypass.
// Optional performance counters are built when CDB_PERF_EN is defined.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int QUEUE_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rb,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_src,
    input  logic [WORD_W-1:0]    alu_val,
    output logic                 alu_full,
    input  logic                 ld_valid,
    input  logic [ROB_IDX_W-1:0] ld_src,
    input  logic [WORD_W-1:0]    ld_val,
    output logic                 ld_full,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_src,
    output logic [WORD_W-1:0]    cdb_val
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]          perf_conflict_cnt,
    output logic [31:0]          perf_full_cnt
`endif
);

    logic                 alu_empty, ld_empty;
    logic [ROB_IDX_W-1:0] alu_head_src, ld_head_src;
    logic [WORD_W-1:0]    alu_head_val, ld_head_val;
    logic                 alu_cand_v, ld_cand_v, conflict, any_cand, grant_ld;
    logic                 alu_push, alu_pop, ld_push, ld_pop;
    logic [ROB_IDX_W-1:0] win_src;
    logic [WORD_W-1:0]    win_val;

    logic                 cdb_valid_q;
    logic [ROB_IDX_W-1:0] cdb_src_q;
    logic [WORD_W-1:0]    cdb_val_q;
    src_e                 last_grant_q;

    // A queued head always beats the same source's bypass so per-source order is FIFO.
    always_comb begin
        alu_cand_v = !alu_empty || alu_valid;
        ld_cand_v  = !ld_empty || ld_valid;
        conflict   = alu_cand_v && ld_cand_v;
        any_cand   = alu_cand_v || ld_cand_v;
        grant_ld   = conflict ? (last_grant_q == SRC_ALU) : ld_cand_v;
        alu_pop    = any_cand && !grant_ld && !alu_empty;
        ld_pop     = grant_ld && !ld_empty;
        alu_push   = alu_valid && !(any_cand && !grant_ld && alu_empty);
        ld_push    = ld_valid && !(grant_ld && ld_empty);
        win_src    = grant_ld ? (ld_empty ? ld_src : ld_head_src)
                              : (alu_empty ? alu_src : alu_head_src);
        win_val    = grant_ld ? (ld_empty ? ld_val : ld_head_val)
                              : (alu_empty ? alu_val : alu_head_val);
    end

    cdb_src_queue #(.QUEUE_DEPTH(QUEUE_DEPTH), .QUEUE_AW(QUEUE_AW)) u_alu_queue (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(rb),
        .push(alu_push), .push_src(alu_src), .push_val(alu_val), .pop(alu_pop),
        .head_src(alu_head_src), .head_val(alu_head_val),
        .empty(alu_empty), .full(alu_full)
    );

    cdb_src_queue #(.QUEUE_DEPTH(QUEUE_DEPTH), .QUEUE_AW(QUEUE_AW)) u_ld_queue (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(rb),
        .push(ld_push), .push_src(ld_src), .push_val(ld_val), .pop(ld_pop),
        .head_src(ld_head_src), .head_val(ld_head_val),
        .empty(ld_empty), .full(ld_full)
    );

    // Reset and rollback park last_grant on LD so the ALU wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q  <= FALSE;
            cdb_src_q    <= ZERO_ROB_IDX;
            cdb_val_q    <= ZERO_WORD;
            last_grant_q <= SRC_LD;
        end else if (rdy) begin
            if (rb) begin
                cdb_valid_q  <= FALSE;
                last_grant_q <= SRC_LD;
            end else begin
                cdb_valid_q <= any_cand;
                if (any_cand) begin
                    cdb_src_q    <= win_src;
                    cdb_val_q    <= win_val;
                    last_grant_q <= grant_ld ? SRC_LD : SRC_ALU;
                end
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_src   = cdb_src_q;
    assign cdb_val   = cdb_val_q;

`ifdef CDB_PERF_EN
    logic [31:0] conflict_cnt_q, full_cnt_q;

    // Counters survive rollback; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
            full_cnt_q     <= '0;
        end else if (rdy) begin
            if (!rb && conflict) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (alu_full || ld_full) begin
                full_cnt_q <= full_cnt_q + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = conflict_cnt_q;
    assign perf_full_cnt     = full_cnt_q;
`endif

endmodule
